// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// The REGFILE_BYPASS_EN macro (write-first forwarding) is consumed in regfile_read_port.
package regfile_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_NREG   = 32;
    localparam int DEF_NRD    = 2;
    localparam int MAX_NRD    = 4;
    localparam int ZERO_REG   = 0;
    localparam int ADDR_W_MAX = 7;

    // Register 0 and anything beyond the implemented range behave as a hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_W_MAX-1:0] addr, input int nreg);
        return (int'(addr) != ZERO_REG) && (int'(addr) < nreg);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bus of regfile_mp; master drives requests, slave returns read results.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = DEF_NRD
);
    localparam int AW = $clog2(NREG);

    logic [NRD-1:0]      i_rd_en;
    logic [NRD*AW-1:0]   i_rd_addr;
    logic [NRD*XLEN-1:0] o_rd_data;
    logic [NRD-1:0]      o_rd_valid;
    logic [NRD-1:0]      o_rd_busy;
    logic                i_we;
    logic [AW-1:0]       i_wr_addr;
    logic [XLEN-1:0]     i_wr_data;
    logic                i_sb_set;
    logic [AW-1:0]       i_sb_addr;

    modport master (
        output i_rd_en, i_rd_addr, i_we, i_wr_addr, i_wr_data, i_sb_set, i_sb_addr,
        input  o_rd_data, o_rd_valid, o_rd_busy
    );

    modport slave (
        input  i_rd_en, i_rd_addr, i_we, i_wr_addr, i_wr_data, i_sb_set, i_sb_addr,
        output o_rd_data, o_rd_valid, o_rd_busy
    );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: address mux, optional same-cycle write forwarding, output regs.
// Forwarding is compiled only when REGFILE_BYPASS_EN is defined; otherwise reads are read-first.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] regs [NREG],
    input  logic [NREG-1:0] busy,
    input  logic            wr_hit,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            set_hit,
    input  logic [AW-1:0]   sb_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_valid,
    output logic            rd_busy
);

    logic [XLEN-1:0] data_mux;
    logic            busy_mux;
    logic [XLEN-1:0] data_reg;
    logic            busy_reg;
    logic            valid_reg;

    always_comb begin
        data_mux = '0;
        busy_mux = 1'b0;
        if (addr_ok(ADDR_W_MAX'(rd_addr), NREG)) begin
            data_mux = regs[rd_addr];
            busy_mux = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
            // Write-first: a matching write supplies its data and the post-update busy bit,
            // where a simultaneous set on the same register keeps it busy.
            if (wr_hit && (wr_addr == rd_addr)) begin
                data_mux = wr_data;
                busy_mux = set_hit && (sb_addr == rd_addr);
            end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_hit, wr_addr, wr_data, set_hit, sb_addr};
`endif

    // Data and busy hold their last value while the port is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= rd_en;
            if (rd_en) begin
                data_reg <= data_mux;
                busy_reg <= busy_mux;
            end
        end
    end

    assign rd_data  = data_reg;
    assign rd_busy  = busy_reg;
    assign rd_valid = valid_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired zero register and a per-register busy scoreboard.
// Optional write-first forwarding on the read ports is enabled by REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD  = DEF_NRD
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    regfile_mp_if.slave   bus
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic            wr_hit;
    logic            set_hit;

    assign wr_hit  = bus.i_we     && addr_ok(ADDR_W_MAX'(bus.i_wr_addr), NREG);
    assign set_hit = bus.i_sb_set && addr_ok(ADDR_W_MAX'(bus.i_sb_addr), NREG);

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_reg[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wr_hit && (bus.i_wr_addr == AW'(r))) begin
                    regs_reg[r] <= bus.i_wr_data;
                end
            end
        end
    end

    // A write retires the pending producer, but a same-cycle set on that register wins.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_reg <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (set_hit && (bus.i_sb_addr == AW'(r))) begin
                    busy_reg[r] <= 1'b1;
                end else if (wr_hit && (bus.i_wr_addr == AW'(r))) begin
                    busy_reg[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
        regfile_read_port #(
            .XLEN (XLEN),
            .NREG (NREG),
            .AW   (AW)
        ) u_port (
            .clk      (i_clk),
            .rst_n    (i_reset_n),
            .rd_en    (bus.i_rd_en[gi]),
            .rd_addr  (bus.i_rd_addr[gi*AW +: AW]),
            .regs     (regs_reg),
            .busy     (busy_reg),
            .wr_hit   (wr_hit),
            .wr_addr  (bus.i_wr_addr),
            .wr_data  (bus.i_wr_data),
            .set_hit  (set_hit),
            .sb_addr  (bus.i_sb_addr),
            .rd_data  (bus.o_rd_data[gi*XLEN +: XLEN]),
            .rd_valid (bus.o_rd_valid[gi]),
            .rd_busy  (bus.o_rd_busy[gi])
        );
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers (2..64).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL derive local AW = $clog2(NREG), the address width.
REQ-005 SHALL have port i_clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_rd_en, input, NRD, per-port read request.
REQ-008 SHALL have port i_rd_addr, input, NRD*AW, packed read addresses (port p at [p*AW +: AW]).
REQ-009 SHALL have port o_rd_data, output, NRD*XLEN, packed registered read data.
REQ-010 SHALL have port o_rd_valid, output, NRD, one-cycle pulse marking fresh o_rd_data.
REQ-011 SHALL have port o_rd_busy, output, NRD, scoreboard busy bit of the register read.
REQ-012 SHALL have port i_we, input, 1, write enable.
REQ-013 SHALL have port i_wr_addr, input, AW, write address.
REQ-014 SHALL have port i_wr_data, input, XLEN, write data.
REQ-015 SHALL have port i_sb_set, input, 1, mark register busy (pending producer).
REQ-016 SHALL have port i_sb_addr, input, AW, register to mark busy.

Function
REQ-017 SHALL return read data 1 cycle after i_rd_en[p] high, with o_rd_valid[p] high for exactly that cycle.
REQ-018 SHALL hold o_rd_data[p] and o_rd_busy[p] unchanged while i_rd_en[p] is low.
REQ-019 SHALL serve all NRD ports and one write in the same cycle, with no stall or port priority.
REQ-020 SHALL hardwire register 0 to zero: reads give 0 and busy 0; writes and sb_set to 0 are ignored.
REQ-021 SHALL treat addresses >= NREG like register 0: read 0, ignore writes and sets.
REQ-022 SHALL set busy[a] at the edge where i_sb_set is high with i_sb_addr = a.
REQ-023 SHALL clear busy[a] at the edge where i_we is high with i_wr_addr = a.
REQ-024 SHALL let set win when i_sb_set and i_we target the same register in one cycle: data written, busy stays 1.
REQ-025 SHALL return on o_rd_data the register value after the write in the same cycle when read address = write address (see REQ-031).
REQ-026 SHALL return on o_rd_busy the busy value after that cycle's set/clear when read address = write address, applied consistently with o_rd_data.

Reset
REQ-027 SHALL, while i_reset_n is low, asynchronously clear all registers, all busy bits, o_rd_data, o_rd_valid and o_rd_busy to 0.
REQ-028 SHALL discard a read issued in the cycle reset asserts; no o_rd_valid pulse follows.
REQ-029 SHALL accept operations from the first rising edge after i_reset_n deasserts.

Configuration
REQ-030 SHALL compile bypass logic only when macro REGFILE_BYPASS_EN is defined.
REQ-031 SHALL, with REGFILE_BYPASS_EN, forward same-cycle i_wr_data and the post-update busy bit to matching read ports (write-first).
REQ-032 SHALL, without REGFILE_BYPASS_EN, return pre-write data and pre-update busy for a same-cycle matching read (read-first).

Structure
REQ-033 SHALL place default XLEN, default NREG, ZERO_REG = 0 and the NRD limit in shared package regfile_pkg.
REQ-034 SHALL implement one sub-module, regfile_read_port, instantiated NRD times; it contains the address mux, bypass compare and output registers.
REQ-035 SHALL hold storage and the scoreboard in regfile_mp itself.

Verification
REQ-036 SHALL test reset: write 0xDEADBEEF to r5, pulse i_reset_n low mid-cycle, read r5 -> 0, busy 0, o_rd_valid low during reset.
REQ-037 SHALL test write then read: write 0x12345678 to r7; next cycle read r7 on ports 0 and 1 -> both 0x12345678 one cycle later, valid=2'b11.
REQ-038 SHALL test x0: write 0xFFFFFFFF to r0 and sb_set r0; read r0 -> 0, busy 0.
REQ-039 SHALL test same-cycle collision: r3 = 0xA; same cycle write 0xB to r3 and read r3 -> 0xB with REGFILE_BYPASS_EN, 0xA without.
REQ-040 SHALL test scoreboard: sb_set r9, read r9 -> busy 1; write r9 -> busy 0; set and write r9 together -> busy 1, data updated.
REQ-041 SHALL test NREG=24: write to address 30 is ignored; read of address 30 -> 0; reads of r1..r23 unaffected.
